// File: rtl/bin_bcd_pkg.sv
// Shared types and elaboration helpers for the serial binary-to-BCD converter.
package bin_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Decimal digits needed to show the largest unsigned bin_w-bit value.
  function automatic int digits_needed(input int bin_w);
    longint unsigned v;
    int n;
    v = (64'd1 << bin_w) - 64'd1;
    n = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit of the double-dabble correction: add 3 when the digit is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_bcd_seq.sv
// Serial binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// Handshakes: a transfer happens on a rising edge where vld and rdy are both high.
module bin_bcd_seq
  import bin_bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                din_vld,
  output logic                din_rdy,
  input  logic [BIN_W-1:0]    bin_in,
  output logic                dout_vld,
  input  logic                dout_rdy,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                ovf,
  output logic                busy,
  output state_t              dbg_state
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W);

  generate
    if (BIN_W < 2 || BIN_W > 32) begin : g_bad_width
      $fatal(1, "bin_bcd_seq: BIN_W=%0d outside 2..32", BIN_W);
    end
    if (DIGITS < 1 || DIGITS > 10) begin : g_bad_digits
      $fatal(1, "bin_bcd_seq: DIGITS=%0d outside 1..10", DIGITS);
    end
    if (DIGITS < digits_needed(BIN_W)) begin : g_small_digits
      $info("bin_bcd_seq: DIGITS=%0d below %0d needed, large inputs set ovf",
            DIGITS, digits_needed(BIN_W));
    end
  endgenerate

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0] sreg_q, sreg_d;
  logic [BW-1:0]   acc_q, acc_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            ovf_q, ovf_d;
  logic [BW-1:0]   adj;

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (acc_q[4*d +: 4]),
      .dout (adj[4*d +: 4])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (din_vld) begin
          sreg_d  = bin_in;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // The bit leaving the corrected top digit is worth 10**DIGITS.
        acc_d  = {adj[BW-2:0], sreg_q[BIN_W-1]};
        sreg_d = {sreg_q[BIN_W-2:0], 1'b0};
        ovf_d  = ovf_q | adj[BW-1];
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(BIN_W - 1)) begin
          state_d = DONE;
          bcd_d   = acc_d;
        end
      end
      DONE: begin
        if (dout_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign din_rdy   = (state_q == IDLE);
  assign busy      = (state_q == SHIFT);
  assign dout_vld  = (state_q == DONE);
  assign bcd_out   = bcd_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule
